// File: rtl/cla_pkg.sv
// Shared constants and response type for the cla_arb adder-sharing slice.
package cla_pkg;

  localparam int unsigned CLA_W   = 5;
  localparam int unsigned CNT_W   = 16;
  // Wide enough for the largest legal requester count (8).
  localparam int unsigned ID_MAXW = 3;

  typedef struct packed {
    logic               valid;
    logic [ID_MAXW-1:0] id;
    logic [CLA_W-1:0]   sum;
    logic               cout;
  } cla_rsp_t;

endpackage

// File: rtl/cla5.sv
// Combinational 5-bit carry-lookahead adder: {cout, sum} = a + b + cin.
module cla5
  import cla_pkg::*;
(
  input  logic [CLA_W-1:0] a,
  input  logic [CLA_W-1:0] b,
  input  logic             cin,
  output logic [CLA_W-1:0] sum,
  output logic             cout
);

  logic [CLA_W-1:0] g;
  logic [CLA_W-1:0] p;
  logic [CLA_W:0]   c;
  logic             term;

  // Each carry is a flat sum of generate terms gated by the propagates above them.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    term = 1'b0;
    for (int unsigned i = 0; i < CLA_W; i++) begin
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
      term = cin;
      for (int unsigned k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = c[i+1] | term;
    end
  end

  assign sum  = p ^ c[CLA_W-1:0];
  assign cout = c[CLA_W];

endmodule

// File: rtl/cla_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module cla_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int unsigned          k;
  logic [IDW-1:0]       kk;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    kk  = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      k = 32'(ptr) + off;
      if (k >= NREQ) k = k - NREQ;
      kk = IDW'(k);
      if (!any && valid[kk]) begin
        any     = 1'b1;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/cla_arb.sv
// Round-robin arbiter feeding one shared 5-bit CLA through a two-stage pipeline.
// Optional per-requester grant counters: define CLA_ARB_STATS_EN.
module cla_arb
  import cla_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [CLA_W*NREQ-1:0]    req_a,
  input  logic [CLA_W*NREQ-1:0]    req_b,
  input  logic [NREQ-1:0]          req_cin,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [CLA_W-1:0]         rsp_sum,
  output logic                     rsp_cout
`ifdef CLA_ARB_STATS_EN
  ,
  output logic [CNT_W*NREQ-1:0]    gnt_count
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  pick_gnt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             accept;

  logic             s1_valid_q, s1_valid_d;
  logic [CLA_W-1:0] s1_a_q, s1_a_d;
  logic [CLA_W-1:0] s1_b_q, s1_b_d;
  logic             s1_cin_q, s1_cin_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d;

  cla_rsp_t         s2_q, s2_d;
  logic [CLA_W-1:0] add_sum;
  logic             add_cout;
  logic             unused_id_hi;

  cla_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grants are masked while reset is held so no requester sees a handshake.
  assign accept    = pick_any & RST_N;
  assign req_ready = pick_gnt & {NREQ{RST_N}};

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cin_d   = s1_cin_q;
    s1_id_d    = s1_id_q;
    if (accept) begin
      s1_id_d = pick_idx;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (pick_gnt[i]) begin
          s1_a_d   = req_a[i*CLA_W +: CLA_W];
          s1_b_d   = req_b[i*CLA_W +: CLA_W];
          s1_cin_d = req_cin[i];
        end
      end
    end
  end

  cla5 u_cla (
    .a    (s1_a_q),
    .b    (s1_b_q),
    .cin  (s1_cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    s2_d       = '0;
    s2_d.valid = s1_valid_q;
    s2_d.id    = ID_MAXW'(s1_id_q);
    s2_d.sum   = add_sum;
    s2_d.cout  = add_cout;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_id_q    <= '0;
      s2_q       <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_cin_q   <= s1_cin_d;
      s1_id_q    <= s1_id_d;
      s2_q       <= s2_d;
    end
  end

  assign rsp_valid    = s2_q.valid;
  assign rsp_id       = s2_q.id[IDW-1:0];
  assign rsp_sum      = s2_q.sum;
  assign rsp_cout     = s2_q.cout;
  assign unused_id_hi = ^s2_q.id;

`ifdef CLA_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [CNT_W-1:0] cnt_d [NREQ];

  // Saturating counters: stop at all-ones rather than wrapping.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept && pick_gnt[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    gnt_count = '0;
    for (int unsigned i = 0; i < NREQ; i++) gnt_count[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: doc/cla_arb.md
# cla_arb

Round-robin arbiter and pipeline sequencer that shares one 5-bit carry-lookahead adder datapath among NREQ requesters. Each cycle it grants at most one pending operand set, pushes it through a two-stage registered add pipeline (operand register, CLA, result register), and returns the sum tagged with the requester index. It sits between the client blocks and the single adder instance, replacing per-client adders.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(NREQ), requester-index width (derived, not overridable)
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- req_valid  in  NREQ  requester i has an operand set pending
- req_ready  out  NREQ  one-hot grant; bit i high = requester i accepted this cycle
- req_a  in  5*NREQ  operand A of requester i at bits [5i+4:5i]
- req_b  in  5*NREQ  operand B of requester i at bits [5i+4:5i]
- req_cin  in  NREQ  carry-in of requester i
- rsp_valid  out  1  result valid this cycle
- rsp_id  out  IDW  index of requester owning the result
- rsp_sum  out  5  sum bits
- rsp_cout  out  1  carry-out
- gnt_count  out  16*NREQ  per-requester grant counter, bits [16i+15:16i] (only with CLA_ARB_STATS_EN)

## Operation
- Handshake: transfer on req_valid[i] && req_ready[i]. req_ready is combinational from req_valid and the priority pointer; req_ready[i] is never high while req_valid[i] is low. At most one req_ready bit high per cycle.
- Requester must hold req_valid and its operands stable until accepted.
- Arbitration: search starts at pointer ptr, ascending, wrapping NREQ-1 -> 0; first valid requester wins.
- ptr update on a grant to i: ptr <= (i+1) mod NREQ. No grant: ptr unchanged.
- Pipeline stage 1 (on accept): register A, B, Cin, id, s1_valid<=1; else s1_valid<=0 (data regs may hold).
- Pipeline stage 2: CLA result of stage-1 regs registered with id; s2_valid <= s1_valid. Stage-2 regs drive rsp_*.
- Sum: {rsp_cout, rsp_sum} = A + B + Cin, 6-bit exact; no overflow truncation beyond carry-out.
- No response backpressure: result is presented for exactly one cycle; clients must capture it.
- Pipeline never stalls; sustained throughput one operation per cycle.
- Reset (any time, including mid-flight): ptr=0, s1_valid=s2_valid=0, all stage regs 0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, gnt_count=0. In-flight operations discarded, no response issued for them.

## Timing
- Accept at edge t (grant seen during cycle before t) -> rsp_valid high during cycle after edge t+1; latency 2 edges.
- Back-to-back accepts produce back-to-back responses in grant order.
- req_ready is low throughout reset assertion; first grant possible in the first cycle after RST_N deasserts.
- All valid requesters simultaneously: grants rotate ptr, ptr+1, ...; each requester served within NREQ cycles (starvation-free).

## Configuration
- CLA_ARB_STATS_EN defined: gnt_count port present; counter i increments on each accept of requester i, saturates at 16'hFFFF, cleared only by reset.
- Not defined: gnt_count port and counters absent; all other behaviour identical.

## Structure
- Shared package cla_pkg: constant CLA_W = 5, CNT_W = 16, and the response struct (valid, id, sum, cout) type.
- One sub-module: cla_rr_pick (combinational round-robin picker: req_valid, ptr -> one-hot grant, winner index). Adder itself is the existing combinational cla5 instantiated between stages.

## Test plan
- Reset mid-flight: accept req0 (A=5'd3,B=5'd4), assert RST_N low next cycle -> rsp_valid never rises; all outputs 0.
- Single request: req2 A=5'd31,B=5'd1,Cin=0 -> two edges later rsp_valid=1, rsp_id=2, rsp_sum=0, rsp_cout=1, for one cycle.
- Carry-in: req1 A=5'd15,B=5'd15,Cin=1 -> rsp_sum=5'd31, rsp_cout=0.
- All four valid continuously from reset -> grant order 0,1,2,3,0,...; responses one per cycle, ids in same order.
- Sparse contention: ptr=3, only req1 and req2 valid -> req1 granted, ptr=2; next cycle req2 granted.
- Stats (CLA_ARB_STATS_EN): 70000 consecutive grants to req0 alone -> gnt_count[15:0]=16'hFFFF, others 0.
